// File: rtl/ldcnt_updn_p_if.sv
`default_nettype none
// ============================================================================
//  Module      : ldcnt_updn_p_if
//  Description : Control/data bundle for the loadable up/down counter.
//                The master drives the controls; the counter (slave) drives
//                the value, the cascade carry and the terminal-count pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ldcnt_updn_p_if #(
    parameter int WIDTH = 8
) ();
    logic             SP;   // clock enable
    logic             SD;   // load select
    logic [WIDTH-1:0] D;    // parallel load value
    logic             UP;   // direction
    logic             CI;   // carry / count enable in
    logic [WIDTH-1:0] Q;    // counter value
    logic             CO;   // cascade carry out
    logic             TCP;  // terminal-count pulse

    modport master (
        output SP, SD, D, UP, CI,
        input  Q, CO, TCP
    );

    modport slave (
        input  SP, SD, D, UP, CI,
        output Q, CO, TCP
    );
endinterface
`default_nettype wire

// File: rtl/ldcnt_updn_p.sv
`default_nettype none
// ============================================================================
//  Module      : ldcnt_updn_p
//  Description : Parametrised loadable up/down counter with programmable
//                modulus, combinational cascade carry and a registered
//                terminal-count pulse.
//                Optional macro LDCNT_SAT_EN: saturate at the bounds instead
//                of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldcnt_updn_p #(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MODULUS   = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  wire logic     CK,
    input  wire logic     CD,
    ldcnt_updn_p_if.slave bus
);

    localparam logic [WIDTH-1:0] c_MAX   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] c_RESET = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);

`ifdef LDCNT_SAT_EN
    // Saturating: a step attempted at a bound lands on (or clamps to) that bound.
    localparam logic [WIDTH-1:0] c_UP_BOUND_NEXT = c_MAX;
    localparam logic [WIDTH-1:0] c_DN_BOUND_NEXT = '0;
`else
    // Wrapping: stepping past a bound jumps to the opposite bound.
    localparam logic [WIDTH-1:0] c_UP_BOUND_NEXT = '0;
    localparam logic [WIDTH-1:0] c_DN_BOUND_NEXT = c_MAX;
`endif

    logic [WIDTH-1:0] r_q;
    logic             r_tcp;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_q_count;

    // A loaded value above MAX counts as "at the top" so the next up-step
    // resolves it back into range.
    assign w_at_max   = (r_q >= c_MAX);
    assign w_at_zero  = (r_q == '0);
    assign w_at_bound = bus.UP ? w_at_max : w_at_zero;

    // Next value for a qualified count step in the current direction.
    always_comb begin
        w_q_count = r_q;
        if (bus.UP) begin
            w_q_count = w_at_max ? c_UP_BOUND_NEXT : (r_q + c_ONE);
        end else begin
            w_q_count = w_at_zero ? c_DN_BOUND_NEXT : (r_q - c_ONE);
        end
    end

    // Counter and terminal-count register: reset > load > count > hold.
    always_ff @(posedge CK) begin
        if (CD) begin
            r_q   <= c_RESET;
            r_tcp <= 1'b0;
        end else if (bus.SP && bus.SD) begin
            r_q   <= bus.D;
            r_tcp <= 1'b0;
        end else if (bus.SP && bus.CI) begin
            r_q   <= w_q_count;
            r_tcp <= w_at_bound;
        end else begin
            r_tcp <= 1'b0;
        end
    end

    // Carry out ignores SP/SD so cascaded stages chain combinationally.
    assign bus.CO  = bus.CI & w_at_bound;
    assign bus.Q   = r_q;
    assign bus.TCP = r_tcp;

endmodule
`default_nettype wire

// File: tb/tb_ldcnt_updn_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ldcnt_updn_p
//  Description : Self-checking bench for ldcnt_updn_p (WIDTH=4, MODULUS=10,
//                RESET_VAL=3) plus an 8-bit cascade of two 4-bit counters.
//                Honours LDCNT_SAT_EN when defined for the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ldcnt_updn_p;

    localparam int MAXV = 9;
    localparam int RV   = 3;
`ifdef LDCNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       cd, sp, sd, up, ci;
    logic [3:0] d;
    logic       c_sp, c_sd, c_up, c_ci;
    logic [7:0] c_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ldcnt_updn_p_if #(.WIDTH(4)) bus ();
    ldcnt_updn_p_if #(.WIDTH(4)) lo_if ();
    ldcnt_updn_p_if #(.WIDTH(4)) hi_if ();

    assign bus.SP = sp;
    assign bus.SD = sd;
    assign bus.D  = d;
    assign bus.UP = up;
    assign bus.CI = ci;

    assign lo_if.SP = c_sp;
    assign lo_if.SD = c_sd;
    assign lo_if.D  = c_d[3:0];
    assign lo_if.UP = c_up;
    assign lo_if.CI = c_ci;
    assign hi_if.SP = c_sp;
    assign hi_if.SD = c_sd;
    assign hi_if.D  = c_d[7:4];
    assign hi_if.UP = c_up;
    assign hi_if.CI = lo_if.CO;

    ldcnt_updn_p #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut (
        .CK (clk),
        .CD (cd),
        .bus(bus.slave)
    );

    ldcnt_updn_p #(.WIDTH(4)) u_lo (
        .CK (clk),
        .CD (cd),
        .bus(lo_if.slave)
    );

    ldcnt_updn_p #(.WIDTH(4)) u_hi (
        .CK (clk),
        .CD (cd),
        .bus(hi_if.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the main counter, in plain integer arithmetic.
    int m_q     = 0;
    bit m_tcp   = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (cd) begin
            m_q     <= RV;
            m_tcp   <= 1'b0;
            m_valid <= 1'b1;
        end else if (sp && sd) begin
            m_q   <= int'(d);
            m_tcp <= 1'b0;
        end else if (sp && ci) begin
            if (up) begin
                if (m_q >= MAXV) begin
                    m_q   <= SAT ? MAXV : 0;
                    m_tcp <= 1'b1;
                end else begin
                    m_q   <= m_q + 1;
                    m_tcp <= 1'b0;
                end
            end else begin
                if (m_q == 0) begin
                    m_q   <= SAT ? 0 : MAXV;
                    m_tcp <= 1'b1;
                end else begin
                    m_q   <= m_q - 1;
                    m_tcp <= 1'b0;
                end
            end
        end else begin
            m_tcp <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_Q", 32'(bus.Q), 32'(m_q));
            check("model_TCP", 32'(bus.TCP), 32'(m_tcp));
            check("model_CO", 32'(bus.CO), 32'(ci && (up ? (m_q >= MAXV) : (m_q == 0))));
        end
    end

    task automatic set_in(input logic i_cd, input logic i_sp, input logic i_sd,
                          input logic [3:0] i_d, input logic i_up, input logic i_ci);
        cd = i_cd; sp = i_sp; sd = i_sd; d = i_d; up = i_up; ci = i_ci;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_up[7];
        int cv;
        exp_up = '{4, 5, 6, 7, 8, 9, 0};
        c_sp = 1'b0; c_sd = 1'b0; c_up = 1'b1; c_ci = 1'b0; c_d = 8'h00;

        // Reset.
        set_in(1, 0, 0, 4'h0, 1, 0);
        step();
        check("reset_Q", 32'(bus.Q), 32'd3);
        check("reset_TCP", 32'(bus.TCP), 32'd0);
        check("reset_CO", 32'(bus.CO), 32'd0);

`ifndef LDCNT_SAT_EN
        // Up-count through the wrap.
        for (int i = 0; i < 7; i++) begin
            set_in(0, 1, 0, 4'h0, 1, 1);
            step();
            check("up_Q", 32'(bus.Q), 32'(exp_up[i]));
            check("up_TCP", 32'(bus.TCP), (i == 6) ? 32'd1 : 32'd0);
        end

        // Down-count from 1 through the wrap, with carry-out probes at 0.
        set_in(0, 1, 1, 4'h1, 0, 0);
        step();
        set_in(0, 1, 0, 4'h0, 0, 1);
        step();
        check("dn_Q0", 32'(bus.Q), 32'd0);
        check("dn_TCP0", 32'(bus.TCP), 32'd0);
        set_in(0, 0, 0, 4'h0, 0, 1);
        #1;
        check("co_at_zero", 32'(bus.CO), 32'd1);
        ci = 1'b0;
        #1;
        check("co_ci_low", 32'(bus.CO), 32'd0);
        set_in(0, 1, 0, 4'h0, 0, 1);
        step();
        check("dn_Q9", 32'(bus.Q), 32'd9);
        check("dn_TCP9", 32'(bus.TCP), 32'd1);

        // Out-of-range load then up-count wraps to 0.
        set_in(0, 1, 1, 4'hE, 1, 1);
        step();
        check("load_E", 32'(bus.Q), 32'd14);
        set_in(0, 1, 0, 4'h0, 1, 1);
        step();
        check("loadE_up_Q", 32'(bus.Q), 32'd0);
        check("loadE_up_TCP", 32'(bus.TCP), 32'd1);

        // Out-of-range load then down-count decrements normally.
        set_in(0, 1, 1, 4'hF, 0, 1);
        step();
        set_in(0, 1, 0, 4'h0, 0, 1);
        step();
        check("loadF_dn_Q", 32'(bus.Q), 32'd14);
        check("loadF_dn_TCP", 32'(bus.TCP), 32'd0);
`else
        // Saturating: three up-steps at MAX hold 9 and pulse each time.
        set_in(0, 1, 1, 4'h9, 1, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 4'h0, 1, 1);
            step();
            check("sat_up_Q", 32'(bus.Q), 32'd9);
            check("sat_up_TCP", 32'(bus.TCP), 32'd1);
        end
        set_in(0, 1, 1, 4'h0, 0, 0);
        step();
        set_in(0, 1, 0, 4'h0, 0, 1);
        step();
        check("sat_dn_Q", 32'(bus.Q), 32'd0);
        check("sat_dn_TCP", 32'(bus.TCP), 32'd1);
        set_in(0, 1, 1, 4'hE, 1, 0);
        step();
        set_in(0, 1, 0, 4'h0, 1, 1);
        step();
        check("sat_clamp_Q", 32'(bus.Q), 32'd9);
`endif

        // Load happens regardless of CI.
        set_in(0, 1, 1, 4'h7, 1, 0);
        step();
        check("load_ci0", 32'(bus.Q), 32'd7);

        // Priority: reset over load, SP gates load, reset masks a wrap pulse.
        set_in(1, 1, 1, 4'h5, 1, 1);
        step();
        check("prio_cd_load", 32'(bus.Q), 32'd3);
        set_in(0, 0, 1, 4'h8, 1, 1);
        step();
        check("prio_sp0_hold", 32'(bus.Q), 32'd3);
        set_in(0, 1, 1, 4'h9, 1, 1);
        step();
        set_in(1, 1, 0, 4'h0, 1, 1);
        step();
        check("prio_cd_wrap_Q", 32'(bus.Q), 32'd3);
        check("prio_cd_wrap_TCP", 32'(bus.TCP), 32'd0);

        // Cascade: 8'h0F + 1 carries into the high nibble on the same edge.
        set_in(0, 0, 0, 4'h0, 1, 0);
        c_sp = 1'b1; c_sd = 1'b1; c_d = 8'h0F; c_up = 1'b1; c_ci = 1'b0;
        step();
        check("casc_load", 32'({hi_if.Q, lo_if.Q}), 32'h0F);
        c_sd = 1'b0; c_ci = 1'b1;
        step();
`ifndef LDCNT_SAT_EN
        check("casc_Q", 32'({hi_if.Q, lo_if.Q}), 32'h10);
`else
        check("casc_Q", 32'({hi_if.Q, lo_if.Q}), 32'h1F);
`endif
        check("casc_lo_TCP", 32'(lo_if.TCP), 32'd1);
        check("casc_hi_TCP", 32'(hi_if.TCP), 32'd0);

`ifndef LDCNT_SAT_EN
        // Random cascade steps behave as one 8-bit counter modulo 256.
        cv = int'({hi_if.Q, lo_if.Q});
        for (int i = 0; i < 60; i++) begin
            c_up = 1'($urandom_range(0, 1));
            c_ci = ($urandom_range(0, 3) != 0);
            step();
            if (c_ci) cv = c_up ? ((cv + 1) % 256) : ((cv + 255) % 256);
            check("casc_rand", 32'({hi_if.Q, lo_if.Q}), 32'(cv));
        end
`endif
        c_sp = 1'b0; c_ci = 1'b0;

        // Randomised traffic on the main counter, checked by the model.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 39) == 0),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0),
                   4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) != 0));
            step();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
